// File: rtl/sim_run_ctrl.sv
// Simulation run controller: counts cycles/retires, stops on halt/PC/cycle limit, then streams a state dump.
// Optional data-memory dump enabled by defining SIM_RUN_CTRL_MEMDUMP_EN.
module sim_run_ctrl #(
    parameter int CNT_W    = 32,
    parameter int NREG     = 32,
    parameter int DM_WORDS = 128,
    parameter int DM_AW    = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             retire,
    input  logic [31:0]      pc,
    input  logic             halt_req,
    input  logic [CNT_W-1:0] cfg_stop_cnt,
    input  logic [31:0]      cfg_stop_pc,
    input  logic             cfg_pc_en,
    output logic [4:0]       reg_sel,
    input  logic [31:0]      reg_data,
    output logic [DM_AW-1:0] dm_addr,
    input  logic [31:0]      dm_data,
    output logic             dump_valid,
    input  logic             dump_ready,
    output logic             dump_kind,
    output logic [15:0]      dump_idx,
    output logic [31:0]      dump_data,
    output logic             cpu_stall,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retire_cnt,
    output logic [1:0]       stop_cause,
    output logic             done
);

    typedef enum logic [1:0] {RUN, DUMP_REG, DUMP_MEM, DONE} state_t;

    localparam logic [15:0]      REG_LAST = 16'(NREG - 1);
    localparam logic [15:0]      MEM_LAST = 16'(DM_WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0]   retire_cnt_q, retire_cnt_d;
    logic [1:0]         stop_cause_q, stop_cause_d;
    logic               dump_valid_q, dump_valid_d;
    logic               dump_kind_q, dump_kind_d;
    logic [15:0]        dump_idx_q, dump_idx_d;
    logic [31:0]        dump_data_q, dump_data_d;
    logic               cpu_stall_q, cpu_stall_d;
    logic               done_q, done_d;

    logic [CNT_W-1:0]   cycle_inc;
    logic               pc_hit;
    logic               limit_hit;
    logic [31:0]        fetch_data;

    assign cycle_inc = cycle_cnt_q + CNT_W'(1);
    assign pc_hit    = retire && cfg_pc_en && (pc == cfg_stop_pc);
    assign limit_hit = (cfg_stop_cnt != '0) && (cycle_inc == cfg_stop_cnt);

    assign reg_sel = (state_q == DUMP_REG) ? dump_idx_q[4:0] : '0;

`ifdef SIM_RUN_CTRL_MEMDUMP_EN
    assign dm_addr = (state_q == DUMP_MEM) ? dump_idx_q[DM_AW-1:0] : '0;
`else
    logic unused_dm;
    assign unused_dm = ^dm_data;
    assign dm_addr   = '0;
`endif

    // Register entry 0 is the hard-wired zero register, so its read port is not trusted.
    always_comb begin
        fetch_data = (dump_idx_q == '0) ? '0 : reg_data;
`ifdef SIM_RUN_CTRL_MEMDUMP_EN
        if (state_q == DUMP_MEM) fetch_data = dm_data;
`endif
    end

    always_comb begin
        state_d      = state_q;
        cycle_cnt_d  = cycle_cnt_q;
        retire_cnt_d = retire_cnt_q;
        stop_cause_d = stop_cause_q;
        dump_valid_d = dump_valid_q;
        dump_kind_d  = dump_kind_q;
        dump_idx_d   = dump_idx_q;
        dump_data_d  = dump_data_q;

        unique case (state_q)
            RUN: begin
                if (cycle_cnt_q != CNT_MAX) cycle_cnt_d = cycle_inc;
                if (retire && retire_cnt_q != CNT_MAX) retire_cnt_d = retire_cnt_q + CNT_W'(1);
                if (halt_req || pc_hit || limit_hit) begin
                    state_d      = DUMP_REG;
                    stop_cause_d = halt_req ? 2'd1 : (pc_hit ? 2'd2 : 2'd3);
                    dump_valid_d = 1'b0;
                    dump_kind_d  = 1'b0;
                    dump_idx_d   = '0;
                end
            end
            DUMP_REG, DUMP_MEM: begin
                // dump_valid low marks the FETCH cycle; high is the HOLD phase.
                if (!dump_valid_q) begin
                    dump_valid_d = 1'b1;
                    dump_data_d  = fetch_data;
                end else if (dump_ready) begin
                    dump_valid_d = 1'b0;
                    if (state_q == DUMP_REG && dump_idx_q == REG_LAST) begin
`ifdef SIM_RUN_CTRL_MEMDUMP_EN
                        state_d     = DUMP_MEM;
                        dump_kind_d = 1'b1;
`else
                        state_d     = DONE;
`endif
                        dump_idx_d  = '0;
                    end else if (state_q == DUMP_MEM && dump_idx_q == MEM_LAST) begin
                        state_d = DONE;
                    end else begin
                        dump_idx_d = dump_idx_q + 16'd1;
                    end
                end
            end
            DONE: ;
            default: state_d = RUN;
        endcase

        cpu_stall_d = (state_d != RUN);
        done_d      = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            cycle_cnt_q  <= '0;
            retire_cnt_q <= '0;
            stop_cause_q <= '0;
            dump_valid_q <= 1'b0;
            dump_kind_q  <= 1'b0;
            dump_idx_q   <= '0;
            dump_data_q  <= '0;
            cpu_stall_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cycle_cnt_q  <= cycle_cnt_d;
            retire_cnt_q <= retire_cnt_d;
            stop_cause_q <= stop_cause_d;
            dump_valid_q <= dump_valid_d;
            dump_kind_q  <= dump_kind_d;
            dump_idx_q   <= dump_idx_d;
            dump_data_q  <= dump_data_d;
            cpu_stall_q  <= cpu_stall_d;
            done_q       <= done_d;
        end
    end

    assign cycle_cnt  = cycle_cnt_q;
    assign retire_cnt = retire_cnt_q;
    assign stop_cause = stop_cause_q;
    assign dump_valid = dump_valid_q;
    assign dump_kind  = dump_kind_q;
    assign dump_idx   = dump_idx_q;
    assign dump_data  = dump_data_q;
    assign cpu_stall  = cpu_stall_q;
    assign done       = done_q;

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Testbench for sim_run_ctrl: table-driven stop scenarios plus hand-written dump sequences.
module tb_sim_run_ctrl;

    localparam int CNT_W    = 32;
    localparam int NREG     = 32;
    localparam int DM_WORDS = 128;
    localparam int DM_AW    = 7;

    logic             clk = 1'b0;
    logic             rst;
    logic             retire;
    logic [31:0]      pc;
    logic             halt_req;
    logic [CNT_W-1:0] cfg_stop_cnt;
    logic [31:0]      cfg_stop_pc;
    logic             cfg_pc_en;
    logic [4:0]       reg_sel;
    logic [31:0]      reg_data;
    logic [DM_AW-1:0] dm_addr;
    logic [31:0]      dm_data;
    logic             dump_valid;
    logic             dump_ready;
    logic             dump_kind;
    logic [15:0]      dump_idx;
    logic [31:0]      dump_data;
    logic             cpu_stall;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] retire_cnt;
    logic [1:0]       stop_cause;
    logic             done;

    sim_run_ctrl #(.CNT_W(CNT_W), .NREG(NREG), .DM_WORDS(DM_WORDS), .DM_AW(DM_AW)) dut (
        .clk(clk), .rst(rst), .retire(retire), .pc(pc), .halt_req(halt_req),
        .cfg_stop_cnt(cfg_stop_cnt), .cfg_stop_pc(cfg_stop_pc), .cfg_pc_en(cfg_pc_en),
        .reg_sel(reg_sel), .reg_data(reg_data), .dm_addr(dm_addr), .dm_data(dm_data),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_kind(dump_kind),
        .dump_idx(dump_idx), .dump_data(dump_data), .cpu_stall(cpu_stall),
        .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt), .stop_cause(stop_cause), .done(done)
    );

    always #5 clk = ~clk;

    // Register file model: entry 0 holds junk so the forced-zero beat is observable.
    assign reg_data = (reg_sel == 5'd0) ? 32'hDEAD_BEEF : {27'd0, reg_sel} * 32'h11;
    assign dm_data  = 32'hD000_0000 ^ ({25'd0, dm_addr} * 32'h0101_0001);

    typedef struct {
        int         halt_at;
        int         pcm_at;
        bit         pc_en;
        int         stop_cnt;
        bit         ret_all;
        logic [1:0] exp_cause;
        int         exp_cyc;
        int         exp_ret;
    } vec_t;

    vec_t vecs[7];
    int   checks = 0;
    int   passes = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1; retire = 1'b0; halt_req = 1'b0; dump_ready = 1'b0;
        pc = 32'h0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic run_to_stop(input vec_t v, output int stall_at);
        cfg_stop_cnt = v.stop_cnt;
        cfg_pc_en    = v.pc_en;
        cfg_stop_pc  = 32'h40;
        stall_at     = -1;
        for (int n = 1; n <= 400; n++) begin
            retire   = v.ret_all || (n == v.pcm_at);
            pc       = (n == v.pcm_at) ? 32'h40 : 32'h1000 + 32'(4 * n);
            halt_req = (n == v.halt_at);
            @(posedge clk); #1;
            if (cpu_stall) begin
                stall_at = n;
                break;
            end
        end
        retire   = 1'b0;
        halt_req = 1'b0;
    endtask

    function automatic logic [48:0] exp_beat(input int b);
        int m;
        if (b < NREG) return {1'b0, 16'(b), (b == 0) ? 32'h0 : 32'(b) * 32'h11};
        m = b - NREG;
        return {1'b1, 16'(m), 32'hD000_0000 ^ (32'(m) * 32'h0101_0001)};
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   stall_at, beats, last_hs, w, tk, ti, found, stable, exp_beats;
        logic [31:0] hold_data;
        logic [15:0] hold_idx;
        vec_t v;

        //           halt pcm en  cnt  all cause cyc ret
        vecs[0] = '{0,   0,  0, 200, 1, 2'd3, 200, 200};
        vecs[1] = '{17,  17, 1, 0,   1, 2'd1, 17,  17};
        vecs[2] = '{0,   10, 1, 0,   0, 2'd2, 10,  1};
        vecs[3] = '{0,   10, 0, 25,  0, 2'd3, 25,  1};
        vecs[4] = '{0,   0,  0, 1,   0, 2'd3, 1,   0};
        vecs[5] = '{5,   0,  0, 5,   1, 2'd1, 5,   5};
        vecs[6] = '{0,   8,  1, 8,   1, 2'd2, 8,   8};

        cfg_stop_cnt = '0; cfg_stop_pc = '0; cfg_pc_en = 1'b0;
        do_reset();
        check("reset_ctrl", {cpu_stall, done, dump_valid, dump_kind, stop_cause}, 6'd0);
        check("reset_cnt", {cycle_cnt, retire_cnt}, 64'd0);
        check("reset_dump", {dump_idx, dump_data, reg_sel, dm_addr}, 60'd0);

        foreach (vecs[i]) begin
            do_reset();
            run_to_stop(vecs[i], stall_at);
            check($sformatf("v%0d_stall_at", i), 64'(stall_at), 64'(vecs[i].exp_cyc));
            check($sformatf("v%0d_cause", i), 64'(stop_cause), 64'(vecs[i].exp_cause));
            check($sformatf("v%0d_cycle", i), 64'(cycle_cnt), 64'(vecs[i].exp_cyc));
            check($sformatf("v%0d_retire", i), 64'(retire_cnt), 64'(vecs[i].exp_ret));
        end

        // Full dump with ready held high.
        v = '{2, 0, 0, 0, 1, 2'd1, 2, 2};
        do_reset();
        run_to_stop(v, stall_at);
        dump_ready = 1'b1;
        beats = 0; last_hs = -100;
        for (int t = 0; t < 2000 && !done; t++) begin
            @(posedge clk); #1;
            if (dump_valid && dump_ready) begin
                check($sformatf("beat%0d", beats), 64'({dump_kind, dump_idx, dump_data}), 64'(exp_beat(beats)));
                if (beats > 0) check($sformatf("beat%0d_gap", beats), 64'(t - last_hs), 64'd2);
                last_hs = t;
                beats++;
            end
        end
`ifdef SIM_RUN_CTRL_MEMDUMP_EN
        exp_beats = NREG + DM_WORDS;
`else
        exp_beats = NREG;
`endif
        check("beat_count", 64'(beats), 64'(exp_beats));
        check("done_state", {done, cpu_stall, reg_sel, dm_addr}, {2'b11, 12'd0});
        repeat (3) @(posedge clk);
        #1 check("done_terminal", {done, dump_valid}, 2'b10);
        dump_ready = 1'b0;

        // Backpressure on beat 3; counters must stay frozen while CPU inputs toggle.
        do_reset();
        v = '{3, 0, 0, 0, 1, 2'd1, 3, 3};
        run_to_stop(v, stall_at);
        retire = 1'b1; halt_req = 1'b1;
        for (int b = 0; b < 5; b++) begin
            w = 0;
            while (!dump_valid && w < 8) begin
                @(posedge clk); #1;
                w++;
            end
            check($sformatf("bp_fetch%0d", b), 64'(w), 64'd1);
            check($sformatf("bp_idx%0d", b), 64'(dump_idx), 64'(b));
            if (b == 3) begin
                check("bp_data3", 64'(dump_data), 64'h33);
                hold_data = dump_data; hold_idx = dump_idx; stable = 1;
                repeat (10) begin
                    @(posedge clk); #1;
                    if (!dump_valid || dump_idx !== hold_idx || dump_data !== hold_data || dump_kind !== 1'b0)
                        stable = 0;
                end
                check("bp_hold_stable", 64'(stable), 64'd1);
            end
            dump_ready = 1'b1;
            @(posedge clk); #1;
            dump_ready = 1'b0;
            check($sformatf("bp_hs%0d", b), 64'(dump_valid), 64'd0);
        end
        check("bp_frozen", {cycle_cnt, retire_cnt}, {32'd3, 32'd3});
        check("bp_cause", 64'(stop_cause), 64'd1);
        retire = 1'b0; halt_req = 1'b0;

        // Reset asserted mid-handshake.
        do_reset();
        v = '{2, 0, 0, 0, 1, 2'd1, 2, 2};
        run_to_stop(v, stall_at);
`ifdef SIM_RUN_CTRL_MEMDUMP_EN
        tk = 1; ti = 40;
`else
        tk = 0; ti = 20;
`endif
        dump_ready = 1'b1;
        found = 0;
        for (int t = 0; t < 2000; t++) begin
            @(posedge clk); #1;
            if (dump_valid && dump_kind == 1'(tk) && dump_idx == 16'(ti)) begin
                found = 1;
                break;
            end
        end
        check("rst_target_found", 64'(found), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; dump_ready = 1'b0;
        check("rst_ctrl", {cpu_stall, done, dump_valid, dump_kind, stop_cause}, 6'd0);
        check("rst_cnt", {cycle_cnt, retire_cnt}, 64'd0);
        check("rst_dump", {dump_idx, dump_data, reg_sel, dm_addr}, 60'd0);
        cfg_stop_cnt = '0;
        @(posedge clk); #1;
        check("rst_running", {cpu_stall, cycle_cnt}, 33'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
